// File: rtl/cnn_pkg.sv
// Shared types and defaults for the CNN frame sequencer and its watchdog.
package cnn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT,
        DONE,
        ERROR
    } seq_state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_TIMEOUT  = 2'd1,
        ERR_SPURIOUS = 2'd2
    } err_code_t;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 65536;

endpackage

// File: rtl/cnn_layer_sequencer_watchdog.sv
// Per-stage hang detector: counts WAIT cycles and flags the last permitted one.
module stage_watchdog
    import cnn_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    localparam int unsigned CNT_W         = $clog2(TIMEOUT_CYCLES)
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    assign o_expired = (r_count == TERMINAL);

    // Holds at terminal count so the flag stays asserted until cleared.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expired) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/cnn_layer_sequencer.sv
// Frame-level controller: launches each CNN layer in order via start/done pulses,
// measures frame latency and watchdogs every stage for hangs and stray done pulses.
module cnn_layer_sequencer
    import cnn_pkg::*;
#(
    parameter int unsigned NUM_STAGES     = 5,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int unsigned CNT_WIDTH      = 32,
    localparam int unsigned IDX_W         = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_valid,
    output logic                  frame_ready,
    input  logic                  abort,
    output logic [NUM_STAGES-1:0] stage_start,
    input  logic [NUM_STAGES-1:0] stage_done,
    output logic                  busy,
    output logic [IDX_W-1:0]      cur_stage,
    output logic                  result_valid,
    output logic [CNT_WIDTH-1:0]  cycle_count,
    output logic                  error,
    output logic [1:0]            err_code,
    output logic [IDX_W-1:0]      err_stage
);

    localparam logic [NUM_STAGES-1:0] ONE_HOT0  = NUM_STAGES'(1);
    localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NUM_STAGES - 1);

    seq_state_t            r_state;
    logic [IDX_W-1:0]      r_idx;
    logic [CNT_WIDTH-1:0]  r_cycle_count;
    logic [NUM_STAGES-1:0] r_stage_start;
    logic                  r_frame_ready;
    logic                  r_busy;
    logic                  r_result_valid;
    logic                  r_error;
    err_code_t             r_err_code;
    logic [IDX_W-1:0]      r_err_stage;

    logic [IDX_W-1:0]      w_next_idx;
    logic [NUM_STAGES-1:0] w_idx_onehot;
    logic [NUM_STAGES-1:0] w_next_onehot;
    logic [NUM_STAGES-1:0] w_stray_done;
    logic                  w_last_stage;
    logic                  w_in_flight;
    logic                  w_wd_clear;
    logic                  w_wd_enable;
    logic                  w_wd_expired;

    assign w_next_idx    = r_idx + 1'b1;
    assign w_idx_onehot  = ONE_HOT0 << r_idx;
    assign w_next_onehot = ONE_HOT0 << w_next_idx;
    assign w_stray_done  = stage_done & ~w_idx_onehot;
    assign w_last_stage  = (r_idx == LAST_IDX);
    assign w_in_flight   = (r_state == LAUNCH) || (r_state == WAIT);
    assign w_wd_clear    = (r_state == LAUNCH);
    assign w_wd_enable   = (r_state == WAIT);

    stage_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_wd_clear),
        .i_enable  (w_wd_enable),
        .o_expired (w_wd_expired)
    );

    // Abort must suppress a pulse already registered for the current cycle.
    assign stage_start  = r_stage_start & {NUM_STAGES{~abort}};
    assign result_valid = r_result_valid & ~abort;
    assign frame_ready  = r_frame_ready;
    assign busy         = r_busy;
    assign cur_stage    = r_idx;
    assign cycle_count  = r_cycle_count;
    assign error        = r_error;
    assign err_code     = r_err_code;
    assign err_stage    = r_err_stage;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_idx          <= '0;
            r_cycle_count  <= '0;
            r_stage_start  <= '0;
            r_frame_ready  <= 1'b1;
            r_busy         <= 1'b0;
            r_result_valid <= 1'b0;
            r_error        <= 1'b0;
            r_err_code     <= ERR_NONE;
            r_err_stage    <= '0;
        end else begin
            r_stage_start  <= '0;
            r_result_valid <= 1'b0;

            if (w_in_flight && !abort && (r_cycle_count != '1)) begin
                r_cycle_count <= r_cycle_count + 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (frame_valid) begin
                        r_state       <= LAUNCH;
                        r_idx         <= '0;
                        r_cycle_count <= '0;
                        r_stage_start <= ONE_HOT0;
                        r_frame_ready <= 1'b0;
                        r_busy        <= 1'b1;
                    end
                end

                LAUNCH: begin
                    if (abort) begin
                        r_state       <= IDLE;
                        r_busy        <= 1'b0;
                        r_frame_ready <= 1'b1;
                    end else if (|stage_done) begin
                        r_state       <= ERROR;
                        r_busy        <= 1'b0;
                        r_error       <= 1'b1;
                        r_err_code    <= ERR_SPURIOUS;
                        r_err_stage   <= r_idx;
                    end else begin
                        r_state <= WAIT;
                    end
                end

                WAIT: begin
                    if (abort) begin
                        r_state       <= IDLE;
                        r_busy        <= 1'b0;
                        r_frame_ready <= 1'b1;
                    end else if (|w_stray_done) begin
                        r_state       <= ERROR;
                        r_busy        <= 1'b0;
                        r_error       <= 1'b1;
                        r_err_code    <= ERR_SPURIOUS;
                        r_err_stage   <= r_idx;
                    end else if (|(stage_done & w_idx_onehot)) begin
                        if (w_last_stage) begin
                            r_state        <= DONE;
                            r_busy         <= 1'b0;
                            r_result_valid <= 1'b1;
                        end else begin
                            r_state       <= LAUNCH;
                            r_idx         <= w_next_idx;
                            r_stage_start <= w_next_onehot;
                        end
                    end else if (w_wd_expired) begin
                        r_state     <= ERROR;
                        r_busy      <= 1'b0;
                        r_error     <= 1'b1;
                        r_err_code  <= ERR_TIMEOUT;
                        r_err_stage <= r_idx;
                    end
                end

                DONE: begin
                    if (abort) begin
                        r_state       <= IDLE;
                        r_frame_ready <= 1'b1;
                    end else if (|stage_done) begin
                        r_state     <= ERROR;
                        r_error     <= 1'b1;
                        r_err_code  <= ERR_SPURIOUS;
                        r_err_stage <= r_idx;
                    end else begin
                        r_state       <= IDLE;
                        r_frame_ready <= 1'b1;
                    end
                end

                ERROR: begin
                    if (abort) begin
                        r_state       <= IDLE;
                        r_frame_ready <= 1'b1;
                        r_error       <= 1'b0;
                        r_err_code    <= ERR_NONE;
                        r_err_stage   <= '0;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Scoreboard bench for cnn_layer_sequencer: directed frames with hand-derived
// start/result/error timing, checked by an independent negedge monitor.
module tb_cnn_layer_sequencer;

    localparam int NS = 5;
    localparam int TO = 16;

    typedef struct {
        int cyc;
        int a;
        int b;
    } ev_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          frame_valid;
    logic          frame_ready;
    logic          abort;
    logic [NS-1:0] stage_start;
    logic [NS-1:0] stage_done = '0;
    logic          busy;
    logic [2:0]    cur_stage;
    logic          result_valid;
    logic [31:0]   cycle_count;
    logic          error;
    logic [1:0]    err_code;
    logic [2:0]    err_stage;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    ev_t start_q[$];
    ev_t res_q[$];
    ev_t err_q[$];

    int            lat [NS];
    int            cnt [NS] = '{default: 0};
    logic [NS-1:0] inj = '0;
    logic [NS-1:0] model_done;

    cnn_layer_sequencer #(
        .NUM_STAGES     (NS),
        .TIMEOUT_CYCLES (TO),
        .CNT_WIDTH      (32)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .frame_valid  (frame_valid),
        .frame_ready  (frame_ready),
        .abort        (abort),
        .stage_start  (stage_start),
        .stage_done   (stage_done),
        .busy         (busy),
        .cur_stage    (cur_stage),
        .result_valid (result_valid),
        .cycle_count  (cycle_count),
        .error        (error),
        .err_code     (err_code),
        .err_stage    (err_stage)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    endtask

    // Layer model: raises done lat[i] cycles after seeing its start pulse (lat 0 = hang).
    always @(posedge clk) begin
        #2;
        model_done = '0;
        for (int i = 0; i < NS; i++) begin
            if (cnt[i] > 0) begin
                cnt[i]--;
                if (cnt[i] == 0) model_done[i] = 1'b1;
            end
            if (stage_start[i] && lat[i] > 0) cnt[i] = lat[i];
        end
        stage_done = model_done | inj;
    end

    initial begin : monitor
        ev_t e;
        logic prev_err;
        logic [NS-1:0] exp_oh;
        prev_err = 1'b0;
        forever begin
            @(negedge clk);
            if (stage_start != '0) begin
                if (start_q.size() == 0) begin
                    check("unexpected_start", stage_start, 0);
                end else begin
                    e = start_q.pop_front();
                    exp_oh = NS'(1) << e.a;
                    check("start_cycle", cyc, e.cyc);
                    check("start_onehot", stage_start, exp_oh);
                end
            end
            if (result_valid) begin
                if (res_q.size() == 0) begin
                    check("unexpected_result", result_valid, 0);
                end else begin
                    e = res_q.pop_front();
                    check("result_cycle", cyc, e.cyc);
                    check("result_cycle_count", cycle_count, e.a);
                    check("result_error", error, 0);
                end
            end
            if (error && !prev_err) begin
                if (err_q.size() == 0) begin
                    check("unexpected_error", error, 0);
                end else begin
                    e = err_q.pop_front();
                    check("error_cycle", cyc, e.cyc);
                    check("error_code", err_code, e.a);
                    check("error_stage", err_stage, e.b);
                    check("error_frame_ready", frame_ready, 0);
                    check("error_busy", busy, 0);
                end
            end
            prev_err = error;
        end
    end

    initial begin : global_limit
        #200000;
        $display("FAIL global_timeout: simulation exceeded time budget at cycle %0d", cyc);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) tick();
    endtask

    // Acceptance edge is the next edge after frame_valid is raised.
    task automatic start_frame(output int t);
        frame_valid = 1'b1;
        t = cyc + 1;
        tick();
        frame_valid = 1'b0;
    endtask

    task automatic push_frame(input int t, input int last, input bit with_result);
        int s;
        s = t;
        for (int i = 0; i <= last; i++) begin
            start_q.push_back('{cyc: s, a: i, b: 0});
            s += lat[i] + 1;
        end
        if (with_result) res_q.push_back('{cyc: s, a: s - t, b: 0});
    endtask

    initial begin : stimulus
        int t;
        int t2;
        reset       = 1'b1;
        frame_valid = 1'b0;
        abort       = 1'b0;
        for (int i = 0; i < NS; i++) lat[i] = 10;

        repeat (3) tick();
        reset = 1'b0;
        check("rst_frame_ready", frame_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_stage_start", stage_start, 0);
        check("rst_result_valid", result_valid, 0);
        check("rst_error", error, 0);
        check("rst_err_code", err_code, 0);
        check("rst_cycle_count", cycle_count, 0);
        check("rst_cur_stage", cur_stage, 0);
        tick();

        // Happy path: starts at +0,+11,...,+44, result at +55 with count 55.
        start_frame(t);
        push_frame(t, NS - 1, 1'b1);
        wait_to(t + 58);
        check("happy_frame_ready", frame_ready, 1);
        check("happy_count_frozen", cycle_count, 55);

        // Back-to-back: second acceptance two edges after the result edge.
        frame_valid = 1'b1;
        t = cyc + 1;
        push_frame(t, NS - 1, 1'b1);
        t2 = t + 57;
        push_frame(t2, NS - 1, 1'b1);
        wait_to(t2);
        frame_valid = 1'b0;
        check("b2b_count_restart", cycle_count, 0);
        check("b2b_busy", busy, 1);
        wait_to(t2 + 58);
        check("b2b_frame_ready", frame_ready, 1);

        // Timeout on stage 2 after 16 WAIT cycles.
        lat[2] = 0;
        start_frame(t);
        push_frame(t, 2, 1'b0);
        err_q.push_back('{cyc: t + 39, a: 1, b: 2});
        wait_to(t + 41);
        check("to_error", error, 1);
        check("to_frame_ready", frame_ready, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("to_abort_error", error, 0);
        check("to_abort_err_code", err_code, 0);
        check("to_abort_err_stage", err_stage, 0);
        check("to_abort_frame_ready", frame_ready, 1);
        lat[2] = 10;
        tick();

        // Spurious done[3] while stage 1 waits, then done[1]|done[3] together.
        for (int k = 0; k < 2; k++) begin
            start_frame(t);
            push_frame(t, 1, 1'b0);
            err_q.push_back('{cyc: t + 14, a: 2, b: 1});
            wait_to(t + 13);
            inj = (k == 0) ? 5'b01000 : 5'b01010;
            tick();
            inj = '0;
            wait_to(t + 25);
            check("spur_error_held", error, 1);
            abort = 1'b1;
            tick();
            abort = 1'b0;
            check("spur_abort_frame_ready", frame_ready, 1);
            tick();
        end

        // Stage 0 done on its 16th WAIT cycle: done beats the timeout.
        lat[0] = 16;
        start_frame(t);
        push_frame(t, NS - 1, 1'b1);
        wait_to(t + 64);
        check("coinc_error", error, 0);
        check("coinc_frame_ready", frame_ready, 1);
        lat[0] = 10;

        // Abort in the third WAIT cycle of stage 3.
        start_frame(t);
        push_frame(t, 3, 1'b0);
        wait_to(t + 36);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_frame_ready", frame_ready, 1);
        check("abort_cur_stage", cur_stage, 3);
        check("abort_cycle_count", cycle_count, 36);
        repeat (3) tick();
        check("abort_count_held", cycle_count, 36);
        wait_to(t + 50);

        // Reset while stage 0 is being launched.
        start_frame(t);
        start_q.push_back('{cyc: t, a: 0, b: 0});
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_frame_ready", frame_ready, 1);
        check("midrst_busy", busy, 0);
        check("midrst_stage_start", stage_start, 0);
        check("midrst_cycle_count", cycle_count, 0);
        check("midrst_cur_stage", cur_stage, 0);
        check("midrst_error", error, 0);
        wait_to(t + 20);

        check("start_q_drained", start_q.size(), 0);
        check("res_q_drained", res_q.size(), 0);
        check("err_q_drained", err_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cnn_layer_sequencer.md
# cnn_layer_sequencer

Frame-level controller that runs the CNN layer datapaths (conv2d, relu, maxpool, dense, argmax) in a fixed order using each layer's start-pulse/done-pulse interface. It accepts one frame at a time, launches each stage only after the previous stage reports done, and measures total frame latency. It also watchdogs every stage for hangs and protocol violations. It sits between the top-level input loader and the layer instances.

## Interface
- NUM_STAGES, 5, number of sequenced layers; stage 0 runs first.
- TIMEOUT_CYCLES, 65536, maximum WAIT cycles allowed per stage before a timeout; must be ≥ 2.
- CNT_WIDTH, 32, width of the frame cycle counter.
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- frame_valid  in  1  input frame is loaded and ready to process.
- frame_ready  out  1  sequencer can accept a frame.
- abort  in  1  cancels the frame in flight and clears the error state.
- stage_start  out  NUM_STAGES  one-hot, one-cycle start pulse to stage i.
- stage_done  in  NUM_STAGES  one-cycle done pulse from stage i.
- busy  out  1  a frame is in flight (LAUNCH or WAIT).
- cur_stage  out  $clog2(NUM_STAGES)  index of the active stage.
- result_valid  out  1  one-cycle pulse when the final stage completes.
- cycle_count  out  CNT_WIDTH  cycles from frame acceptance to completion.
- error  out  1  sticky error flag.
- err_code  out  2  0 none, 1 timeout, 2 spurious done.
- err_stage  out  $clog2(NUM_STAGES)  stage index when the error was latched.

## Operation
- Reset values: all outputs are 0 except frame_ready=1. State is IDLE, idx=0, cycle_count=0.
- IDLE
  - frame_ready=1.
  - On frame_valid&&frame_ready: idx←0, cycle_count←0, go to LAUNCH.
- LAUNCH
  - stage_start[idx]=1 for exactly this cycle; watchdog count←0; go to WAIT.
- WAIT
  - stage_start=0; the watchdog counts once per cycle.
  - stage_done[idx]=1: if idx==NUM_STAGES-1 go to DONE, else idx←idx+1 and go to LAUNCH.
  - No done and watchdog==TIMEOUT_CYCLES-1: go to ERROR, err_code←1.
  - If the correct done and the timeout occur in the same cycle, done wins.
- DONE
  - result_valid=1 for one cycle; cycle_count freezes; go to IDLE.
- ERROR
  - error=1, frame_ready=0, busy=0.
  - Stays until abort or reset; abort returns to IDLE and clears error, err_code and err_stage.
- Spurious done:
  - Any stage_done bit ≠ idx in WAIT, or any stage_done bit in LAUNCH or DONE, goes to ERROR with err_code←2 and err_stage←idx.
  - stage_done is ignored in IDLE and ERROR.
  - A spurious bit in WAIT outranks the correct done bit.
- abort (in LAUNCH, WAIT or DONE): go to IDLE next cycle. stage_start is forced 0 that cycle, result_valid is not pulsed, cycle_count holds. In IDLE, abort has no effect.
- Priority order: reset > abort > spurious done > correct done > timeout.
- cycle_count increments every cycle in LAUNCH and WAIT and saturates at all-ones. The value is valid when result_valid is high and holds until the next acceptance.
- cur_stage=idx in every state; err_stage is latched at error entry.

## Timing
- Accept at edge T: stage_start[0] high in cycle T+1; WAIT begins at T+2.
- Done sampled at edge D: stage_start[idx+1] high in cycle D+1. Each stage adds 1 cycle of overhead beyond its own latency.
- The last stage's done at edge D gives result_valid in cycle D+1 and frame_ready=1 from D+2.
- cycle_count = Σ(stage WAIT cycles) + NUM_STAGES.
- A timeout is declared on the TIMEOUT_CYCLES-th WAIT cycle without done; ERROR is visible the next cycle.
- frame_valid is not consumed outside IDLE. The upstream must hold it until the handshake.
- Reset mid-frame: all outputs return to their reset values on the next edge. No stage_start is emitted.

## Structure
- Shared package cnn_pkg holds:
  - seq_state_t enum {IDLE, LAUNCH, WAIT, DONE, ERROR};
  - err_code_t {ERR_NONE, ERR_TIMEOUT, ERR_SPURIOUS};
  - the default TIMEOUT_CYCLES constant.
- One sub-module, stage_watchdog: a clear/enable counter with a terminal-count flag at TIMEOUT_CYCLES-1, instantiated once.
- Everything else lives in a single FSM plus counters in cnn_layer_sequencer.

## Test plan
- Happy path, NUM_STAGES=5: each stage model returns done 10 cycles after its start.
  - Expect start pulses in cycles 1, 12, 23, 34, 45 after acceptance.
  - Expect result_valid at cycle 56; cycle_count=55; error=0.
- Back-to-back frames: frame_valid held high.
  - Expect the second acceptance exactly 1 cycle after result_valid.
  - Expect cycle_count to restart at 0 and exactly one stage_start per stage per frame.
- Timeout, TIMEOUT_CYCLES=16: stage 2 never asserts done.
  - Expect error=1, err_code=1, err_stage=2 after 16 WAIT cycles, and frame_ready=0.
  - Then abort: expect IDLE, error=0, frame_ready=1.
- Spurious done: stage_done[3] pulses while idx=1 is in WAIT.
  - Expect err_code=2, err_stage=1 and no further stage_start.
  - Repeat with stage_done[1] and [3] together: still err_code=2.
- Done coincident with the last timeout cycle: expect a normal advance and no error.
- Abort and reset mid-frame:
  - Abort during stage 3 WAIT: IDLE next cycle, no result_valid, cycle_count held.
  - Reset asserted during LAUNCH: all outputs at reset values, frame_ready=1.
